alu_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the shared 16-bit combinational ALU (op 00 AND, 01 OR, 10 ADD, 11 SUB). It accepts operations over valid/ready handshakes, grants the ALU round-robin, drives the ALU operand and op inputs from registered state, and returns result and carry on per-requester response channels. It sits between the ALU instance and its two clients at the top level.

---
 rtl/alu_arbiter.sv | 150 +++++++++++++++
 tb/tb_alu_arbiter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter and sequencer for a shared 16-bit combinational ALU.
// Defining ALU_ARB_FLAGS_EN adds registered zero/neg/ovf flags on each response channel.
module alu_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [1:0]  req0_op,
    input  logic [15:0] req0_a,
    input  logic [15:0] req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [1:0]  req1_op,
    input  logic [15:0] req1_a,
    input  logic [15:0] req1_b,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic [15:0] rsp0_data,
    output logic        rsp0_cout,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [15:0] rsp1_data,
    output logic        rsp1_cout,
    output logic [1:0]  alu_op,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    input  logic [15:0] alu_o,
    input  logic        alu_cout,
`ifdef ALU_ARB_FLAGS_EN
    output logic        rsp0_zero,
    output logic        rsp0_neg,
    output logic        rsp0_ovf,
    output logic        rsp1_zero,
    output logic        rsp1_neg,
    output logic        rsp1_ovf,
`endif
    output logic        busy
);
    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;
    state_t      state_q, state_d;
    logic        last_q, last_d, owner_q, owner_d;
    logic [1:0]  op_q, op_d;
    logic [15:0] a_q, a_d, b_q, b_d;
    logic [15:0] data0_q, data0_d, data1_q, data1_d;
    logic        cout0_q, cout0_d, cout1_q, cout1_d;
    logic        any_valid, grant, accept, rsp_hs, cap0, cap1;

    // Contention goes to whoever did not finish the previous transaction.
    assign any_valid = req0_valid || req1_valid;
    assign grant     = (req0_valid && req1_valid) ? !last_q : req1_valid;
    assign accept    = (state_q == IDLE) && any_valid;
    assign rsp_hs    = (state_q == RESP) && (owner_q ? rsp1_ready : rsp0_ready);
    assign cap0      = (state_q == EXEC) && !owner_q;
    assign cap1      = (state_q == EXEC) && owner_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = accept ? EXEC : IDLE;
            EXEC:    state_d = RESP;
            RESP:    state_d = rsp_hs ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req0_ready = (state_q == IDLE) && any_valid && !grant && rst_n;
        req1_ready = (state_q == IDLE) && any_valid && grant && rst_n;
        rsp0_valid = (state_q == RESP) && !owner_q;
        rsp1_valid = (state_q == RESP) && owner_q;
        busy       = state_q != IDLE;
    end

    always_comb begin
        last_d  = rsp_hs ? owner_q : last_q;
        owner_d = accept ? grant : owner_q;
        op_d    = accept ? (grant ? req1_op : req0_op) : op_q;
        a_d     = accept ? (grant ? req1_a : req0_a) : a_q;
        b_d     = accept ? (grant ? req1_b : req0_b) : b_q;
        data0_d = cap0 ? alu_o : data0_q;
        cout0_d = cap0 ? (op_q[1] && alu_cout) : cout0_q;
        data1_d = cap1 ? alu_o : data1_q;
        cout1_d = cap1 ? (op_q[1] && alu_cout) : cout1_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q  <= 1'b1;
            owner_q <= 1'b0;
            op_q    <= 2'b00;
            a_q     <= 16'h0000;
            b_q     <= 16'h0000;
            data0_q <= 16'h0000;
            cout0_q <= 1'b0;
            data1_q <= 16'h0000;
            cout1_q <= 1'b0;
        end else begin
            last_q  <= last_d;
            owner_q <= owner_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            data0_q <= data0_d;
            cout0_q <= cout0_d;
            data1_q <= data1_d;
            cout1_q <= cout1_d;
        end
    end

    assign alu_op    = op_q;
    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign rsp0_data = data0_q;
    assign rsp0_cout = cout0_q;
    assign rsp1_data = data1_q;
    assign rsp1_cout = cout1_q;

`ifdef ALU_ARB_FLAGS_EN
    logic [2:0] flags_c, flags0_q, flags0_d, flags1_q, flags1_d;
    logic       ovf_c;

    // Signed overflow: operand signs (b inverted for SUB) agree but result sign differs.
    assign ovf_c   = (op_q == 2'b10) ? ((a_q[15] == b_q[15]) && (alu_o[15] != a_q[15])) :
                     (op_q == 2'b11) ? ((a_q[15] != b_q[15]) && (alu_o[15] != a_q[15])) : 1'b0;
    assign flags_c = {alu_o == 16'h0000, alu_o[15], ovf_c};

    always_comb begin
        flags0_d = cap0 ? flags_c : flags0_q;
        flags1_d = cap1 ? flags_c : flags1_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags0_q <= 3'b000;
            flags1_q <= 3'b000;
        end else begin
            flags0_q <= flags0_d;
            flags1_q <= flags1_d;
        end
    end

    assign {rsp0_zero, rsp0_neg, rsp0_ovf} = flags0_q;
    assign {rsp1_zero, rsp1_neg, rsp1_ovf} = flags1_q;
`endif
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed self-checking bench for alu_arbiter with a behavioural ALU attached.
module tb_alu_arbiter;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0, req0_ready, req1_ready;
    logic [1:0]  req0_op = 2'b00, req1_op = 2'b00;
    logic [15:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic        rsp0_valid, rsp1_valid, rsp0_ready = 1'b0, rsp1_ready = 1'b0;
    logic [15:0] rsp0_data, rsp1_data;
    logic        rsp0_cout, rsp1_cout;
    logic [1:0]  alu_op;
    logic [15:0] alu_a, alu_b, alu_o;
    logic        alu_cout, busy;
    logic [16:0] sum;
`ifdef ALU_ARB_FLAGS_EN
    logic        rsp0_zero, rsp0_neg, rsp0_ovf, rsp1_zero, rsp1_neg, rsp1_ovf;
`endif
    int n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    always_comb begin
        sum      = (alu_op == 2'b11) ? {1'b0, alu_a} + {1'b0, ~alu_b} + 17'd1 : {1'b0, alu_a} + {1'b0, alu_b};
        alu_o    = (alu_op == 2'b00) ? (alu_a & alu_b) : (alu_op == 2'b01) ? (alu_a | alu_b) : sum[15:0];
        alu_cout = sum[16];
    end

    alu_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data), .rsp0_cout(rsp0_cout),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data), .rsp1_cout(rsp1_cout),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_o(alu_o), .alu_cout(alu_cout),
`ifdef ALU_ARB_FLAGS_EN
        .rsp0_zero(rsp0_zero), .rsp0_neg(rsp0_neg), .rsp0_ovf(rsp0_ovf),
        .rsp1_zero(rsp1_zero), .rsp1_neg(rsp1_neg), .rsp1_ovf(rsp1_ovf),
`endif
        .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic p, input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] ed, input logic ec, input logic [2:0] ef, input logic cf);
        if (p) begin
            req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
        end else begin
            req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
        end
        #1;
        check("req_ready", 32'(p ? req1_ready : req0_ready), 1);
        check("other_ready", 32'(p ? req0_ready : req1_ready), 0);
        tick;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check("exec_busy", 32'(busy), 1);
        check("exec_no_rsp", 32'(rsp0_valid | rsp1_valid), 0);
        check("alu_op", 32'(alu_op), 32'(op));
        check("alu_ab", {alu_a, alu_b}, {a, b});
        tick;
        check("rsp_valid", 32'(p ? rsp1_valid : rsp0_valid), 1);
        check("other_rsp_valid", 32'(p ? rsp0_valid : rsp1_valid), 0);
        check("rsp_data", 32'(p ? rsp1_data : rsp0_data), 32'(ed));
        check("rsp_cout", 32'(p ? rsp1_cout : rsp0_cout), 32'(ec));
`ifdef ALU_ARB_FLAGS_EN
        if (cf) check("rsp_flags", 32'(p ? {rsp1_zero, rsp1_neg, rsp1_ovf} : {rsp0_zero, rsp0_neg, rsp0_ovf}), 32'(ef));
`endif
        if (p) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
        tick;
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        check("idle_busy", 32'(busy), 0);
        check("idle_rsp_valid", 32'(rsp0_valid | rsp1_valid), 0);
        check("alu_hold", {alu_a, alu_b}, {a, b});
    endtask

    initial begin
        int order[$];
        int when[$];
        tick;
        tick;
        check("rst_ready", 32'({req0_ready, req1_ready}), 0);
        check("rst_rsp_valid", 32'({rsp0_valid, rsp1_valid}), 0);
        check("rst_rsp_data", {rsp0_data, rsp1_data}, 0);
        check("rst_rsp_cout", 32'({rsp0_cout, rsp1_cout}), 0);
        check("rst_alu", {alu_a, alu_b}, 0);
        check("rst_alu_op", 32'(alu_op), 0);
        check("rst_busy", 32'(busy), 0);
        rst_n = 1'b1;
        do_op(1'b0, 2'b10, 16'h0003, 16'h0004, 16'h0007, 1'b0, 3'b000, 1'b0);
        do_op(1'b1, 2'b11, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 3'b010, 1'b1);
        do_op(1'b1, 2'b11, 16'h0007, 16'h0005, 16'h0002, 1'b1, 3'b000, 1'b1);
        do_op(1'b1, 2'b10, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 3'b100, 1'b1);
        check("rsp0_hold", 32'(rsp0_data), 32'h0007);

        // Round robin with both requesters always valid from reset.
        rst_n = 1'b0;
        req0_valid = 1'b1; req0_op = 2'b10; req0_a = 16'h0001; req0_b = 16'h0002;
        req1_valid = 1'b1; req1_op = 2'b01; req1_a = 16'h00F0; req1_b = 16'h000F;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        tick;
        rst_n = 1'b1;
        #1;
        for (int c = 0; c < 13; c++) begin
            if (req0_ready) begin order.push_back(0); when.push_back(c); end
            if (req1_ready) begin order.push_back(1); when.push_back(c); end
            check("rr_one_ready", 32'(req0_ready & req1_ready), 0);
            tick;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (4) tick;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        check("rr_count", order.size(), 5);
        for (int i = 0; i < 4; i++) begin
            check("rr_order", order[i], i % 2);
            check("rr_spacing", when[i + 1] - when[i], 3);
        end
        check("rr_data0", 32'(rsp0_data), 32'h0003);
        check("rr_data1", 32'(rsp1_data), 32'h00FF);
        check("rr_idle", 32'(busy), 0);

        // Response backpressure on req0 while req1 waits.
        req0_valid = 1'b1; req0_op = 2'b10; req0_a = 16'h1111; req0_b = 16'h2222;
        tick;
        req0_valid = 1'b0;
        tick;
        req1_valid = 1'b1; req1_op = 2'b00; req1_a = 16'h0; req1_b = 16'h0;
        #1;
        for (int c = 0; c < 5; c++) begin
            check("bp_valid", 32'(rsp0_valid), 1);
            check("bp_data", 32'(rsp0_data), 32'h3333);
            check("bp_cout", 32'(rsp0_cout), 0);
            check("bp_ready", 32'({req0_ready, req1_ready}), 0);
            check("bp_busy", 32'(busy), 1);
            tick;
        end
        rsp0_ready = 1'b1;
        tick;
        rsp0_ready = 1'b0;
        check("bp_release_busy", 32'(busy), 0);
        check("bp_release_valid", 32'(rsp0_valid), 0);
        check("bp_req1_ready", 32'(req1_ready), 1);
        req1_valid = 1'b0;
        #1;

        do_op(1'b0, 2'b00, 16'hF0F0, 16'h0FF0, 16'h00F0, 1'b0, 3'b000, 1'b1);
        do_op(1'b0, 2'b01, 16'hF0F0, 16'h0FF0, 16'hFFF0, 1'b0, 3'b010, 1'b1);
`ifdef ALU_ARB_FLAGS_EN
        do_op(1'b0, 2'b10, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 3'b011, 1'b1);
        do_op(1'b0, 2'b11, 16'h1234, 16'h1234, 16'h0000, 1'b1, 3'b100, 1'b1);
        do_op(1'b0, 2'b01, 16'hF0F0, 16'h0FF0, 16'hFFF0, 1'b0, 3'b010, 1'b1);
`endif

        // Reset asserted while in EXEC abandons the transaction.
        req0_valid = 1'b1; req0_op = 2'b10; req0_a = 16'h0001; req0_b = 16'h0001;
        tick;
        req0_valid = 1'b0;
        check("ex_busy", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("ex_rst_busy", 32'(busy), 0);
        check("ex_rst_valid", 32'({rsp0_valid, rsp1_valid}), 0);
        check("ex_rst_data", 32'(rsp0_data), 0);
        check("ex_rst_alu", {alu_a, alu_b}, 0);
        check("ex_rst_op", 32'(alu_op), 0);
        check("ex_rst_ready", 32'({req0_ready, req1_ready}), 0);
        tick;
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            check("post_rst_valid", 32'({rsp0_valid, rsp1_valid}), 0);
            check("post_rst_busy", 32'(busy), 0);
            tick;
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
